time_counter: RTL and testbench

Free-running time-of-day source for the clock design. It produces the 17-bit packed time word consumed by the alarm and display blocks. It accepts the same time_set_in / set_time load interface the alarm uses. It also takes minute/hour adjust strobes from the button front end.

---
 rtl/time_counter.sv | 128 ++++++++++++
 tb/tb_time_counter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// time_counter: free-running time-of-day source.
// Keeps hour:minute:second packed as [16:12] hour, [11:6] minute, [5:0] second,
// advances once per TICK_DIV clocks and accepts loads and minute/hour adjusts.
// All outputs are registered; every field of time_out always holds a legal value.
module time_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int PRE_W    = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] time_set_in,
    input  logic        set_time,
    input  logic        inc_min,
    input  logic        inc_hour,
    output logic [16:0] time_out,
    output logic        sec_tick,
    output logic        day_wrap,
    output logic        set_err
);

    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;

    logic       load_valid;

    logic [4:0] adv_hour;
    logic [5:0] adv_min;
    logic [5:0] adv_sec;
    logic       adv_wrap;

    logic [4:0] adj_hour;
    logic [5:0] adj_min;

    assign hour   = time_out[16:12];
    assign minute = time_out[11:6];
    assign second = time_out[5:0];

    assign tick = (prescaler == TICK_LAST);

    assign load_valid = (time_set_in[16:12] < 5'd24) &&
                        (time_set_in[11:6]  < 6'd60) &&
                        (time_set_in[5:0]   < 6'd60);

    // Prescaler: a valid load restarts the second phase; anything else
    // (including a rejected load or an adjust) leaves it free-running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (set_time && load_valid) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // One-second advance with carries from seconds through minutes to hours.
    always_comb begin
        adv_sec  = second;
        adv_min  = minute;
        adv_hour = hour;
        adv_wrap = 1'b0;
        if (second == 6'd59) begin
            adv_sec = 6'd0;
            if (minute == 6'd59) begin
                adv_min = 6'd0;
                if (hour == 5'd23) begin
                    adv_hour = 5'd0;
                    adv_wrap = 1'b1;
                end else begin
                    adv_hour = hour + 5'd1;
                end
            end else begin
                adv_min = minute + 6'd1;
            end
        end else begin
            adv_sec = second + 6'd1;
        end
    end

    // Adjust values: each field wraps on its own, no carry between them.
    always_comb begin
        adj_min  = minute;
        adj_hour = hour;
        if (inc_min) begin
            adj_min = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        end
        if (inc_hour) begin
            adj_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        end
    end

    // Time register and pulses: load beats adjust, adjust beats the tick,
    // and a tick that loses to either is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_out <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
            if (set_time) begin
                if (load_valid) begin
                    time_out <= time_set_in;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (inc_min || inc_hour) begin
                time_out <= {adj_hour, adj_min, second};
            end else if (tick) begin
                time_out <= {adv_hour, adv_min, adv_sec};
                sec_tick <= 1'b1;
                day_wrap <= adv_wrap;
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed vector table for the corner cases, an
// asynchronous reset check, then randomized traffic against a
// seconds-of-day reference model.
module tb_time_counter;

    localparam int TICK_DIV = 4;
    localparam int PRE_W    = 3;

    logic        clk;
    logic        rst;
    logic [16:0] time_set_in;
    logic        set_time;
    logic        inc_min;
    logic        inc_hour;
    logic [16:0] time_out;
    logic        sec_tick;
    logic        day_wrap;
    logic        set_err;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state: time as seconds since midnight plus clocks into the second.
    int m_secs;
    int m_phase;
    logic [16:0] e_time;
    logic        e_st;
    logic        e_dw;
    logic        e_err;

    typedef struct {
        logic        st;
        logic        im;
        logic        ih;
        logic [16:0] tsi;
        logic [16:0] et;
        logic        est;
        logic        edw;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];

    time_counter #(
        .TICK_DIV(TICK_DIV),
        .PRE_W   (PRE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .time_set_in(time_set_in),
        .set_time   (set_time),
        .inc_min    (inc_min),
        .inc_hour   (inc_hour),
        .time_out   (time_out),
        .sec_tick   (sec_tick),
        .day_wrap   (day_wrap),
        .set_err    (set_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] pack(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [16:0] secs_to_word(input int secs);
        return pack(secs / 3600, (secs / 60) % 60, secs % 60);
    endfunction

    function automatic vec_t mk(input logic st, input logic im, input logic ih,
                                input logic [16:0] tsi, input logic [16:0] et,
                                input logic est, input logic edw, input logic eerr);
        vec_t v;
        v.st = st; v.im = im; v.ih = ih; v.tsi = tsi;
        v.et = et; v.est = est; v.edw = edw; v.eerr = eerr;
        return v;
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_phase = 0;
        e_time  = '0;
        e_st    = 1'b0;
        e_dw    = 1'b0;
        e_err   = 1'b0;
    endtask

    // One clock of the reference model, from the behavioural rules only.
    task automatic model_step(input logic st, input logic im, input logic ih,
                              input logic [16:0] tsi);
        logic [16:0] w;
        int h, mi, s, lh, lm, ls;
        bit tick;
        w    = tsi;
        tick = (m_phase == TICK_DIV - 1);
        h    = m_secs / 3600;
        mi   = (m_secs / 60) % 60;
        s    = m_secs % 60;
        e_st  = 1'b0;
        e_dw  = 1'b0;
        e_err = 1'b0;
        if (st) begin
            lh = int'(w[16:12]);
            lm = int'(w[11:6]);
            ls = int'(w[5:0]);
            if (lh < 24 && lm < 60 && ls < 60) begin
                m_secs  = lh * 3600 + lm * 60 + ls;
                m_phase = 0;
            end else begin
                e_err   = 1'b1;
                m_phase = (m_phase + 1) % TICK_DIV;
            end
        end else begin
            m_phase = (m_phase + 1) % TICK_DIV;
            if (im || ih) begin
                if (im) mi = (mi + 1) % 60;
                if (ih) h  = (h + 1) % 24;
                m_secs = h * 3600 + mi * 60 + s;
            end else if (tick) begin
                m_secs = (m_secs + 1) % 86400;
                e_st   = 1'b1;
                e_dw   = (m_secs == 0);
            end
        end
        e_time = secs_to_word(m_secs);
    endtask

    task automatic applyStimulus(input logic st, input logic im, input logic ih,
                                 input logic [16:0] tsi);
        set_time    = st;
        inc_min     = im;
        inc_hour    = ih;
        time_set_in = tsi;
        model_step(st, im, ih, tsi);
        @(posedge clk);
        #1;
        set_time = 1'b0;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
    endtask

    task automatic compare_bit(input string name, input logic act, input logic exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic checkOutput(input string tag, input logic [16:0] et,
                               input logic est, input logic edw, input logic eerr);
        check_count++;
        if (time_out === et) pass_count++;
        else $display("[TB] FAIL %s time_out: got %0d:%0d:%0d, expected %0d:%0d:%0d",
                      tag, time_out[16:12], time_out[11:6], time_out[5:0],
                      et[16:12], et[11:6], et[5:0]);
        compare_bit({tag, " sec_tick"}, sec_tick, est);
        compare_bit({tag, " day_wrap"}, day_wrap, edw);
        compare_bit({tag, " set_err"},  set_err,  eerr);
    endtask

    initial begin
        logic [16:0] z;
        logic [16:0] tsi;
        logic st, im, ih;
        int sel;

        z           = '0;
        rst         = 1'b1;
        set_time    = 1'b0;
        inc_min     = 1'b0;
        inc_hour    = 1'b0;
        time_set_in = '0;
        model_reset();

        // Directed vectors; each row is one clock, expectations after that edge.
        vecs.push_back(mk(0,0,0, z, pack(0,0,0), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(0,0,0), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(0,0,0), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(0,0,1), 1,0,0));
        vecs.push_back(mk(1,0,0, pack(23,59,58), pack(23,59,58), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,58), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,58), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,58), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,59), 1,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,59), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,59), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(23,59,59), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(0,0,0), 1,1,0));
        vecs.push_back(mk(1,0,0, pack(24,0,0), pack(0,0,0), 0,0,1));
        vecs.push_back(mk(0,0,0, z, pack(0,0,0), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(0,0,0), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(0,0,1), 1,0,0));
        vecs.push_back(mk(1,0,0, pack(10,59,30), pack(10,59,30), 0,0,0));
        vecs.push_back(mk(0,1,0, z, pack(10,0,30), 0,0,0));
        vecs.push_back(mk(0,1,1, z, pack(11,1,30), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(11,1,30), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(11,1,31), 1,0,0));
        vecs.push_back(mk(0,0,0, z, pack(11,1,31), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(11,1,31), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(11,1,31), 0,0,0));
        vecs.push_back(mk(1,0,1, pack(5,6,7), pack(5,6,7), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,7), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,7), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,7), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,8), 1,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,8), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,8), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(5,6,8), 0,0,0));
        vecs.push_back(mk(0,0,1, z, pack(6,6,8), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(6,6,8), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(6,6,8), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(6,6,8), 0,0,0));
        vecs.push_back(mk(0,0,0, z, pack(6,6,9), 1,0,0));

        #1;
        checkOutput("reset", pack(0,0,0), 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        checkOutput("after release", pack(0,0,0), 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].im, vecs[i].ih, vecs[i].tsi);
            checkOutput($sformatf("vec%0d", i), vecs[i].et, vecs[i].est,
                        vecs[i].edw, vecs[i].eerr);
        end

        // Async reset landing on a live sec_tick pulse, between edges.
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst", pack(0,0,0), 0, 0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("rst held", pack(0,0,0), 0, 0, 0);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        model_step(1'b0, 1'b0, 1'b0, z);
        checkOutput("first after rst", e_time, e_st, e_dw, e_err);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            st  = ($urandom_range(0, 15) == 0);
            im  = ($urandom_range(0, 7) == 0);
            ih  = ($urandom_range(0, 7) == 0);
            tsi = '0;
            if (st) begin
                sel = $urandom_range(0, 2);
                if (sel == 0)
                    tsi = pack($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                else if (sel == 1)
                    tsi = pack(23, $urandom_range(58, 59), $urandom_range(50, 59));
                else
                    tsi = 17'($urandom);
            end
            applyStimulus(st, im, ih, tsi);
            checkOutput($sformatf("rand%0d", n), e_time, e_st, e_dw, e_err);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
